pc_ifid_stage: RTL and testbench
================================

Name: pc_ifid_stage

Overview:
- PC register, next-PC selection and IF/ID pipeline register of the 5-stage MIPS datapath.
- Consumes the hazard unit's control outputs:
  - PC/IF write-enable: active-high; 0 = load-use stall.
  - ID/IF flush: active-low; 0 = taken branch or jump resolved in ID.
- Redirects fetch to the selected target and squashes the wrong-path instruction in IF/ID.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush or reset.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- pc_if_wr  input  1  1 = PC and IF/ID may update; 0 = hold both (stall).
- id_if_flush  input  1  0 = redirect PC and squash IF/ID; 1 = normal.
- npc_sel  input  2  redirect source: 00 = PC+4, 01 = branch target, 10 = J/JAL target, 11 = JR/JALR register target.
- br_target  input  32  branch target computed in ID.
- j_target  input  32  jump target computed in ID.
- jr_target  input  32  register value for JR/JALR.
- imem_instr  input  32  instruction memory read data for the current pc (combinational IMEM).
- pc  output  32  current fetch address to IMEM.
- ifid_pc  output  32  PC of the instruction held in IF/ID.
- ifid_pc4  output  32  ifid_pc + 4, used for the JAL/JALR link.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- stall_cnt  output  CNT_W  number of stalled cycles.
- flush_cnt  output  CNT_W  number of effective flushes.

Behaviour:
- Reset (rst=0 at a rising edge):
  - pc=RESET_PC; ifid_pc=0; ifid_pc4=0; ifid_instr=NOP_INSTR; ifid_valid=0; stall_cnt=0; flush_cnt=0.
  - Reset overrides every other input.
  - A reset asserted mid-stall or mid-flush discards that event; no counter increments that cycle.
- Each rising edge with rst=1 resolves exactly one case, in priority order:
  1. Stall (pc_if_wr=0):
     - pc, ifid_pc, ifid_pc4, ifid_instr and ifid_valid all hold.
     - id_if_flush and npc_sel are ignored; the branch is re-evaluated in ID next cycle with forwarded operands.
     - stall_cnt += 1.
  2. Flush (pc_if_wr=1, id_if_flush=0):
     - pc <= target chosen by npc_sel.
     - ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc <= pc; ifid_pc4 <= pc+4.
     - flush_cnt += 1.
     - npc_sel=00 with flush is legal: sequential redirect that still squashes.
  3. Normal (pc_if_wr=1, id_if_flush=1):
     - pc <= pc+4; ifid_instr <= imem_instr; ifid_pc <= pc; ifid_pc4 <= pc+4; ifid_valid <= 1.
     - npc_sel is ignored.
- Arithmetic and alignment:
  - PC+4 is 32-bit modulo (32'hFFFF_FFFC + 4 = 0).
  - All redirect targets have bits [1:0] forced to 00 before loading pc.
- No delay slot: a taken branch/jump yields exactly one bubble in IF/ID.
- Counters:
  - Saturate at all-ones; they do not wrap.
  - When a counter is at max, its increment is dropped and the other counter is unaffected.
- Latency: pc changes one edge after the controlling inputs are sampled; the IF/ID outputs are registered, with no combinational path from inputs to outputs.
- State machine (implicit in the priority above): RUN, STALL_HOLD and REDIRECT, evaluated each cycle; no multi-cycle states.

Test Plan:
- Reset release, pc_if_wr=1, id_if_flush=1, IMEM returns 32'h2001_0005 at 0x3000:
  - after 1 edge: pc=0x3004, ifid_pc=0x3000, ifid_instr=0x2001_0005, ifid_valid=1.
  - after 3 edges: pc=0x300C.
- Load-use stall, pc_if_wr=0 for 2 cycles at pc=0x3010:
  - pc stays 0x3010; IF/ID contents unchanged; stall_cnt=2.
  - resume: next edge pc=0x3014.
- Taken BEQ: id_if_flush=0, npc_sel=01, br_target=0x3040, pc=0x3008:
  - next edge pc=0x3040, ifid_valid=0, ifid_instr=0, flush_cnt=1.
  - following edge ifid_valid=1, ifid_pc=0x3040.
- Simultaneous stall and flush (pc_if_wr=0, id_if_flush=0, npc_sel=10):
  - no redirect: pc holds, stall_cnt+1, flush_cnt unchanged.
  - next cycle with pc_if_wr=1 the redirect to j_target takes effect.
- JR with misaligned target: jr_target=0x0000_3047, npc_sel=11, flush → pc=0x3044.
  - wrap check: pc=0xFFFF_FFFC, normal cycle → pc=0.
- Saturation and mid-operation reset:
  - preload stall_cnt to 0xFFFF via 65535 stall cycles; one more stall keeps 0xFFFF.
  - rst=0 during an active flush → pc=0x3000, all counters 0, ifid_valid=0.

Source files
------------

// File: rtl/pc_ifid_stage.sv
// PC register, next-PC selection and IF/ID pipeline register for the
// 5-stage MIPS datapath. Each cycle resolves to exactly one of three modes:
// hold everything for a load-use stall, redirect fetch while squashing IF/ID,
// or advance sequentially. Saturating stall/flush counters support perf debug.
module pc_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_if_wr,
    input  logic             id_if_flush,
    input  logic [1:0]       npc_sel,
    input  logic [31:0]      br_target,
    input  logic [31:0]      j_target,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Per-cycle mode; there is no multi-cycle state, so this is decoded fresh
    // every cycle from the hazard unit's controls.
    typedef enum logic [1:0] {
        MODE_RUN        = 2'b00,
        MODE_STALL_HOLD = 2'b01,
        MODE_REDIRECT   = 2'b10
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0]      pc_r;
    logic [31:0]      ifid_pc_r;
    logic [31:0]      ifid_pc4_r;
    logic [31:0]      ifid_instr_r;
    logic             ifid_valid_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    mode_e            mode_s;
    logic [31:0]      pc4_s;
    logic [31:0]      target_raw_s;
    logic [31:0]      redirect_pc_s;
    logic [CNT_W-1:0] stall_cnt_inc_s;
    logic [CNT_W-1:0] flush_cnt_inc_s;

    // Stall has priority over flush: a branch seen during a stall is
    // re-evaluated in ID next cycle with forwarded operands.
    always_comb begin
        mode_s = MODE_RUN;
        if (!pc_if_wr) begin
            mode_s = MODE_STALL_HOLD;
        end else if (!id_if_flush) begin
            mode_s = MODE_REDIRECT;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Sequential successor, 32-bit modulo so the top of memory wraps to 0.
    always_comb begin
        pc4_s = pc_r + 32'd4;
    end

    // Redirect target select; low two bits are cleared so a misaligned
    // register target still lands on a word boundary.
    always_comb begin
        target_raw_s = pc4_s;
        case (npc_sel)
            2'b00:   target_raw_s = pc4_s;
            2'b01:   target_raw_s = br_target;
            2'b10:   target_raw_s = j_target;
            2'b11:   target_raw_s = jr_target;
            default: target_raw_s = pc4_s;
        endcase
        redirect_pc_s = target_raw_s & ALIGN_MASK;
    end

    // Saturating increments: at all-ones the event is dropped, never wrapped.
    always_comb begin
        stall_cnt_inc_s = stall_cnt_r;
        flush_cnt_inc_s = flush_cnt_r;
        if (stall_cnt_r != CNT_MAX) begin
            stall_cnt_inc_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_inc_s = stall_cnt_r;
        end
        if (flush_cnt_r != CNT_MAX) begin
            flush_cnt_inc_s = flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_inc_s = flush_cnt_r;
        end
    end

    // PC, IF/ID and counter update; reset overrides every mode and discards
    // any stall/flush event of that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r         <= RESET_PC;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            stall_cnt_r  <= CNT_ZERO;
            flush_cnt_r  <= CNT_ZERO;
        end else begin
            case (mode_s)
                MODE_STALL_HOLD: begin
                    stall_cnt_r <= stall_cnt_inc_s;
                end
                MODE_REDIRECT: begin
                    pc_r         <= redirect_pc_s;
                    ifid_pc_r    <= pc_r;
                    ifid_pc4_r   <= pc4_s;
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                    flush_cnt_r  <= flush_cnt_inc_s;
                end
                MODE_RUN: begin
                    pc_r         <= pc4_s;
                    ifid_pc_r    <= pc_r;
                    ifid_pc4_r   <= pc4_s;
                    ifid_instr_r <= imem_instr;
                    ifid_valid_r <= 1'b1;
                end
                default: begin
                    pc_r         <= pc_r;
                    ifid_valid_r <= ifid_valid_r;
                end
            endcase
        end
    end

    assign pc         = pc_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc4   = ifid_pc4_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_valid = ifid_valid_r;
    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Self-checking bench for pc_ifid_stage: directed scenarios from the test
// plan plus randomized control traffic, all compared against a behavioural
// model of the fetch stage kept in this file.
module tb_pc_ifid_stage;

    logic        clk;
    logic        rst;
    logic        pc_if_wr;
    logic        id_if_flush;
    logic [1:0]  npc_sel;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_pc4;
    logic [31:0] m_ifid_instr;
    logic        m_valid;
    int          m_stalls;
    int          m_flushes;

    pc_ifid_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_if_wr    (pc_if_wr),
        .id_if_flush (id_if_flush),
        .npc_sel     (npc_sel),
        .br_target   (br_target),
        .j_target    (j_target),
        .jr_target   (jr_target),
        .imem_instr  (imem_instr),
        .pc          (pc),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr),
        .ifid_valid  (ifid_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2001_0005;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = imem_fn(pc);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge of the reference fetch stage, using the current inputs
    task automatic model_edge();
        logic [31:0] old_pc;
        logic [31:0] tgt;
        old_pc = m_pc;
        if (!rst) begin
            m_pc = 32'h0000_3000; m_ifid_pc = 32'd0; m_ifid_pc4 = 32'd0;
            m_ifid_instr = 32'd0; m_valid = 1'b0; m_stalls = 0; m_flushes = 0;
        end else if (!pc_if_wr) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            m_ifid_pc  = old_pc;
            m_ifid_pc4 = old_pc + 32'd4;
            if (!id_if_flush) begin
                case (npc_sel)
                    2'd1:    tgt = br_target;
                    2'd2:    tgt = j_target;
                    2'd3:    tgt = jr_target;
                    default: tgt = old_pc + 32'd4;
                endcase
                m_pc = tgt - (tgt % 32'd4);
                m_ifid_instr = 32'd0;
                m_valid = 1'b0;
                if (m_flushes < 65535) m_flushes++;
            end else begin
                m_ifid_instr = imem_fn(old_pc);
                m_valid = 1'b1;
                m_pc = old_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc",         pc,                    m_pc);
        check_eq("ifid_pc",    ifid_pc,               m_ifid_pc);
        check_eq("ifid_pc4",   ifid_pc4,              m_ifid_pc4);
        check_eq("ifid_instr", ifid_instr,            m_ifid_instr);
        check_eq("ifid_valid", {31'd0, ifid_valid},   {31'd0, m_valid});
        check_eq("stall_cnt",  {16'd0, stall_cnt},    m_stalls);
        check_eq("flush_cnt",  {16'd0, flush_cnt},    m_flushes);
    endtask

    // Apply inputs, take one edge, advance the model, compare 1 ns later
    task automatic step(input logic wr, input logic fl, input logic [1:0] sel,
                        input logic [31:0] br, input logic [31:0] j, input logic [31:0] jr);
        pc_if_wr = wr; id_if_flush = fl; npc_sel = sel;
        br_target = br; j_target = j; jr_target = jr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic normal();
        step(1'b1, 1'b1, 2'b00, 32'hDEAD_BEE0, 32'hCAFE_0000, 32'h1234_5678);
    endtask

    // Reset applied while a flush is being requested: reset must win
    task automatic do_reset();
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b01, 32'h0000_5000, 32'h0000_6000, 32'h0000_7000);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; pc_if_wr = 1'b1; id_if_flush = 1'b1; npc_sel = 2'b00;
        br_target = 32'd0; j_target = 32'd0; jr_target = 32'd0;

        // Reset state and sequential fetch
        do_reset();
        check_eq("rst_pc", pc, 32'h0000_3000);
        check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
        normal();
        check_eq("tp1_pc", pc, 32'h0000_3004);
        check_eq("tp1_ifid_pc", ifid_pc, 32'h0000_3000);
        check_eq("tp1_instr", ifid_instr, 32'h2001_0005);
        check_eq("tp1_valid", {31'd0, ifid_valid}, 32'd1);
        normal(); normal();
        check_eq("tp1_pc3", pc, 32'h0000_300C);

        // Load-use stall for two cycles at 0x3010
        do_reset();
        for (int i = 0; i < 4; i++) normal();
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 2'b01, 32'h0000_3080, 32'd0, 32'd0);
        check_eq("stall_pc", pc, 32'h0000_3010);
        check_eq("stall_ifid_pc", ifid_pc, 32'h0000_300C);
        check_eq("stall_cnt2", {16'd0, stall_cnt}, 32'd2);
        normal();
        check_eq("stall_resume", pc, 32'h0000_3014);

        // Taken BEQ at 0x3008
        do_reset();
        normal(); normal();
        step(1'b1, 1'b0, 2'b01, 32'h0000_3040, 32'd0, 32'd0);
        check_eq("beq_pc", pc, 32'h0000_3040);
        check_eq("beq_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("beq_instr", ifid_instr, 32'd0);
        check_eq("beq_flush", {16'd0, flush_cnt}, 32'd1);
        normal();
        check_eq("beq_valid2", {31'd0, ifid_valid}, 32'd1);
        check_eq("beq_ifid_pc", ifid_pc, 32'h0000_3040);

        // Simultaneous stall and flush, then the redirect
        do_reset();
        normal();
        step(1'b0, 1'b0, 2'b10, 32'd0, 32'h0000_3100, 32'd0);
        check_eq("sf_pc", pc, 32'h0000_3004);
        check_eq("sf_stall", {16'd0, stall_cnt}, 32'd1);
        check_eq("sf_flush", {16'd0, flush_cnt}, 32'd0);
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'h0000_3100, 32'd0);
        check_eq("sf_redir", pc, 32'h0000_3100);

        // Misaligned JR target, sequential redirect, and PC wrap
        step(1'b1, 1'b0, 2'b11, 32'd0, 32'd0, 32'h0000_3047);
        check_eq("jr_align", pc, 32'h0000_3044);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
        check_eq("seq_flush", pc, 32'h0000_3048);
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'hFFFF_FFFE, 32'd0);
        check_eq("top_pc", pc, 32'hFFFF_FFFC);
        normal();
        check_eq("wrap_pc", pc, 32'h0000_0000);
        check_eq("wrap_pc4", ifid_pc4, 32'h0000_0000);

        // Stall counter saturation, then reset during a flush
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 32'd0);
        check_eq("sat_pre", {16'd0, stall_cnt}, 32'h0000_FFFF);
        step(1'b0, 1'b0, 2'b01, 32'h0000_3200, 32'd0, 32'd0);
        check_eq("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check_eq("sat_flush0", {16'd0, flush_cnt}, 32'd0);
        step(1'b1, 1'b0, 2'b01, 32'h0000_3200, 32'd0, 32'd0);
        check_eq("sat_flush1", {16'd0, flush_cnt}, 32'd1);
        do_reset();
        check_eq("mrst_pc", pc, 32'h0000_3000);
        check_eq("mrst_stall", {16'd0, stall_cnt}, 32'd0);
        check_eq("mrst_flush", {16'd0, flush_cnt}, 32'd0);
        check_eq("mrst_valid", {31'd0, ifid_valid}, 32'd0);

        // Randomized control traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
